hazard_stall_unit: RTL and testbench

Pipeline control block that sits in the ID stage alongside the forwarding logic. It covers the hazards that forwarding cannot resolve: load-use dependencies, taken-branch flushes and data-memory wait states. It drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps a stall-cycle performance counter and a sticky memory-timeout flag.

---
 rtl/hazard_stall_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage stall/flush control for load-use, taken
// branches and data-memory waits, plus a stall counter and timeout flag.
//
// Ports:
//   clk, rst (async, active-high)
//   rs1_ifid, rs2_ifid, uses_rs1_ifid, uses_rs2_ifid, ifid_valid : ID operands
//   rd_idex, memRead_idex, regWrite_idex : EX producer
//   branch_taken_ex : EX redirect
//   dmem_req_exmem, dmem_ready : MEM-stage data memory handshake
//   pc_write_en, ifid_write_en, ifid_flush, idex_write_en, idex_bubble,
//   exmem_write_en, memwb_bubble : pipeline register controls
//   stall_cycles : saturating count of cycles with pc_write_en=0
//   mem_timeout  : sticky, a memory wait exceeded MAX_WAIT cycles
//   in_mem_wait  : FSM is in MEM_WAIT
module hazard_stall_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ifid,
    input  logic [4:0]       rs2_ifid,
    input  logic             uses_rs1_ifid,
    input  logic             uses_rs2_ifid,
    input  logic             ifid_valid,
    input  logic [4:0]       rd_idex,
    input  logic             memRead_idex,
    input  logic             regWrite_idex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_exmem,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_write_en,
    output logic             idex_bubble,
    output logic             exmem_write_en,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout,
    output logic             in_mem_wait
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] WAIT_LIM = 16'(MAX_WAIT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [15:0]      r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             r_mem_timeout;

    logic w_mem_stall;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_waiting;

    assign w_mem_stall = dmem_req_exmem && !dmem_ready;

    assign w_rs1_hit = uses_rs1_ifid && (rs1_ifid == rd_idex);
    assign w_rs2_hit = uses_rs2_ifid && (rs2_ifid == rd_idex);

    assign w_load_use = ifid_valid && memRead_idex && regWrite_idex &&
                        (rd_idex != 5'd0) && (w_rs1_hit || w_rs2_hit);

    // Counted wait cycles: only cycles spent in MEM_WAIT still stalled.
    assign w_waiting = (r_state == MEM_WAIT) && w_mem_stall;

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            RUN:      if (w_mem_stall)  w_next_state = MEM_WAIT;
            MEM_WAIT: if (!w_mem_stall) w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase
    end

    // Freeze wins over branch, branch wins over load-use: a squashed
    // instruction must not hold the front end.
    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        ifid_flush     = 1'b0;
        idex_write_en  = 1'b1;
        idex_bubble    = 1'b0;
        exmem_write_en = 1'b1;
        memwb_bubble   = 1'b0;
        if (w_mem_stall) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            memwb_bubble   = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_waiting) begin
            if (r_wait_cnt != 16'hFFFF) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_timeout <= 1'b0;
        end else if (w_waiting && (r_wait_cnt >= WAIT_LIM)) begin
            r_mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!pc_write_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign mem_timeout  = r_mem_timeout;
    assign in_mem_wait  = (r_state == MEM_WAIT);

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed plan cases then random traffic, checked
// by a queue-based scoreboard against a behavioural model.
module tb_hazard_stall_unit;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 5;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       rs1_ifid = '0;
    logic [4:0]       rs2_ifid = '0;
    logic             uses_rs1_ifid = 1'b0;
    logic             uses_rs2_ifid = 1'b0;
    logic             ifid_valid = 1'b0;
    logic [4:0]       rd_idex = '0;
    logic             memRead_idex = 1'b0;
    logic             regWrite_idex = 1'b0;
    logic             branch_taken_ex = 1'b0;
    logic             dmem_req_exmem = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_write_en;
    logic             idex_bubble;
    logic             exmem_write_en;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;
    logic             in_mem_wait;

    hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
        .uses_rs1_ifid(uses_rs1_ifid), .uses_rs2_ifid(uses_rs2_ifid),
        .ifid_valid(ifid_valid), .rd_idex(rd_idex),
        .memRead_idex(memRead_idex), .regWrite_idex(regWrite_idex),
        .branch_taken_ex(branch_taken_ex),
        .dmem_req_exmem(dmem_req_exmem), .dmem_ready(dmem_ready),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
        .ifid_flush(ifid_flush), .idex_write_en(idex_write_en),
        .idex_bubble(idex_bubble), .exmem_write_en(exmem_write_en),
        .memwb_bubble(memwb_bubble), .stall_cycles(stall_cycles),
        .mem_timeout(mem_timeout), .in_mem_wait(in_mem_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, iv, mr, rw, br, req, rdy, rst;
    } stim_t;

    typedef struct {
        string    tag;
        int       cyc;
        logic [6:0] ctl;
        int       sc;
        logic     to;
        logic     imw;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    string cur_tag = "reset";

    // Model state: length of the current run of frozen cycles, raw
    // number of stall cycles, sticky timeout.
    int   m_run = 0;
    int   m_stalls = 0;
    bit   m_to = 0;
    bit   p_stall_pc = 0;
    bit   p_frozen = 0;
    bit   p_rst = 1;

    function automatic stim_t idle();
        stim_t s;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.u1 = 0; s.u2 = 0; s.iv = 0; s.mr = 0; s.rw = 0;
        s.br = 0; s.req = 0; s.rdy = 0; s.rst = 0;
        return s;
    endfunction

    function automatic stim_t lu5();
        stim_t s;
        s = idle();
        s.rd = 5; s.mr = 1; s.rw = 1; s.rs1 = 5; s.u1 = 1; s.iv = 1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit frozen, hazard;
        @(posedge clk);
        cyc++;
        if (!p_rst) begin
            if (p_stall_pc) m_stalls++;
            if (p_frozen) begin
                m_run++;
                if (m_run > MAX_WAIT) m_to = 1;
            end else begin
                m_run = 0;
            end
        end
        #1;
        rs1_ifid = s.rs1; rs2_ifid = s.rs2; rd_idex = s.rd;
        uses_rs1_ifid = s.u1; uses_rs2_ifid = s.u2; ifid_valid = s.iv;
        memRead_idex = s.mr; regWrite_idex = s.rw;
        branch_taken_ex = s.br; dmem_req_exmem = s.req;
        dmem_ready = s.rdy; rst = s.rst;
        if (s.rst) begin
            m_run = 0; m_stalls = 0; m_to = 0;
        end
        frozen = s.req && !s.rdy;
        hazard = s.iv && s.mr && s.rw && s.rd != 0 &&
                 ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        // ctl = {pc, ifid_we, ifid_flush, idex_we, idex_bub, exmem, mwb_bub}
        if (frozen)      e.ctl = 7'b0000001;
        else if (s.br)   e.ctl = 7'b1111110;
        else if (hazard) e.ctl = 7'b0001110;
        else             e.ctl = 7'b1101010;
        e.tag = cur_tag;
        e.cyc = cyc;
        e.sc  = (m_stalls > SAT) ? SAT : m_stalls;
        e.to  = m_to;
        e.imw = (m_run > 0);
        q.push_back(e);
        p_stall_pc = !e.ctl[6];
        p_frozen   = frozen;
        p_rst      = s.rst;
    endtask

    task automatic chk(input string tag, input string f, input int c,
                       input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s cycle %0d: got %0h want %0h",
                     tag, f, c, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "ctl", e.cyc,
                int'({pc_write_en, ifid_write_en, ifid_flush, idex_write_en,
                      idex_bubble, exmem_write_en, memwb_bubble}),
                int'(e.ctl));
            chk(e.tag, "stall_cycles", e.cyc, int'(stall_cycles), e.sc);
            chk(e.tag, "mem_timeout", e.cyc, int'(mem_timeout), int'(e.to));
            chk(e.tag, "in_mem_wait", e.cyc, int'(in_mem_wait), int'(e.imw));
        end
    end

    task automatic reset_pulse();
        stim_t s;
        s = idle();
        s.rst = 1;
        step(s);
        step(idle());
    endtask

    initial begin
        stim_t s;
        int bound;

        cur_tag = "reset";
        reset_pulse();

        cur_tag = "t1_load_use";
        step(lu5());
        s = lu5(); s.mr = 0;
        step(s);
        step(idle());

        cur_tag = "t2_r0";
        reset_pulse();
        s = lu5(); s.rd = 0; s.rs1 = 0;
        step(s);
        s = lu5(); s.u1 = 0;
        step(s);
        step(idle());

        cur_tag = "t3_branch";
        s = lu5(); s.br = 1;
        step(s);
        step(idle());

        cur_tag = "t4_mem_wait";
        reset_pulse();
        s = idle(); s.req = 1;
        repeat (3) step(s);
        s.rdy = 1;
        step(s);
        step(idle());

        cur_tag = "t5_timeout";
        s = idle(); s.req = 1;
        repeat (6) step(s);
        s.rdy = 1;
        step(s);
        step(idle());
        s.rdy = 0;
        repeat (2) step(s);
        s.rst = 1;
        step(s);
        s.rst = 0;
        step(s);
        step(idle());

        cur_tag = "t6_priority";
        reset_pulse();
        s = lu5(); s.br = 1; s.req = 1;
        repeat (2) step(s);
        s.rdy = 1;
        step(s);
        step(idle());

        cur_tag = "t7_saturate";
        s = lu5();
        repeat (SAT + 3) step(s);
        step(idle());

        cur_tag = "random";
        reset_pulse();
        for (int i = 0; i < 3000; i++) begin
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom);
            s.u2  = 1'($urandom);
            s.iv  = ($urandom_range(0, 7) != 0);
            s.mr  = 1'($urandom);
            s.rw  = ($urandom_range(0, 7) != 0);
            s.br  = ($urandom_range(0, 5) == 0);
            s.req = 1'($urandom);
            s.rdy = ($urandom_range(0, 3) == 0);
            s.rst = ($urandom_range(0, 79) == 0);
            step(s);
        end
        step(idle());

        bound = 0;
        while (q.size() > 0 && bound < 10) begin
            @(posedge clk);
            bound++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
